// File: rtl/xgmii_rx_checker_pkg.sv
// Shared XGMII control characters, header constants, checker FSM encodings and a lane helper.
package xgmii_rx_checker_pkg;

  localparam logic [7:0]  XGMII_START    = 8'hFB;
  localparam logic [7:0]  XGMII_TERM     = 8'hFD;
  localparam logic [7:0]  XGMII_ERR      = 8'hFE;
  localparam logic [7:0]  XGMII_IDLE     = 8'h07;
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IPV4_VER_IHL   = 8'h45;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_PAY  = 2'd2;
  localparam logic [1:0] ST_DROP = 2'd3;

  // Lane 0 is the first byte on the wire.
  function automatic logic [7:0] lane_byte(input logic [63:0] word, input int lane);
    return word[8*lane +: 8];
  endfunction

endpackage

// File: rtl/xgmii_term_detect.sv
// Combinational scan of one XGMII word: lowest terminate lane, error chars, stray control chars.
// Zero latency; no backpressure.
module xgmii_term_detect
  import xgmii_rx_checker_pkg::*;
(
  input  logic [63:0] rxd,
  input  logic [7:0]  rxc,
  output logic        term_valid,
  output logic [2:0]  term_lane,
  output logic        err_char,
  output logic        bad_ctrl
);

  always_comb begin
    term_valid = 1'b0;
    term_lane  = 3'd0;
    err_char   = 1'b0;
    bad_ctrl   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (rxc[i]) begin
        if (lane_byte(rxd, i) == XGMII_ERR) err_char = 1'b1;
        // Only control bytes ahead of the terminate belong to the frame.
        if (!term_valid) begin
          if (lane_byte(rxd, i) == XGMII_TERM) begin
            term_valid = 1'b1;
            term_lane  = 3'(i);
          end else if (lane_byte(rxd, i) != XGMII_IDLE) begin
            bad_ctrl = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/xgmii_rx_checker.sv
// XGMII rx frame checker: delineation, length, Eth/IPv4/UDP header checks, statistics.
// Pulses, last_* and counters update 1 cycle after the terminate word; no backpressure.
module xgmii_rx_checker
  import xgmii_rx_checker_pkg::*;
#(
  parameter logic [15:0] MATCH_UDP_PORT  = 16'd9,
  parameter int          MIN_FRAME_BYTES = 64,
  parameter int          MAX_FRAME_BYTES = 1518,
  parameter int          CNT_W           = 32
) (
  input  logic             clk156,
  input  logic             sys_rst,
  input  logic [63:0]      xgmii_rxd,
  input  logic [7:0]       xgmii_rxc,
  output logic             frame_ok,
  output logic             udp_hit,
  output logic             frame_err,
  output logic [15:0]      last_len,
  output logic [15:0]      last_dst_port,
  output logic [31:0]      last_src_ip,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] udp_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [15:0]      MIN_LEN = 16'(MIN_FRAME_BYTES);
  localparam logic [15:0]      MAX_LEN = 16'(MAX_FRAME_BYTES);
  localparam logic [15:0]      BC_SAT  = 16'(MAX_FRAME_BYTES + 8);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic        term_valid, err_char, bad_ctrl;
  logic [2:0]  term_lane;

  xgmii_term_detect u_term (
    .rxd        (xgmii_rxd),
    .rxc        (xgmii_rxc),
    .term_valid (term_valid),
    .term_lane  (term_lane),
    .err_char   (err_char),
    .bad_ctrl   (bad_ctrl)
  );

  logic [1:0]  state;
  logic [2:0]  wi;
  logic [15:0] bc;
  logic        err_seen, eth_ok, ver_ok, proto_ok;
  logic [15:0] dport;
  logic [31:0] src_ip;

  logic        is_start, in_frame, word_err, end_err, udp_ok;
  logic [15:0] bc_next, end_len;

  always_comb begin
    is_start = xgmii_rxc[0] && (lane_byte(xgmii_rxd, 0) == XGMII_START);
    in_frame = (state != ST_IDLE);
    word_err = err_char || bad_ctrl;
    bc_next  = (bc > BC_SAT - 16'd8) ? BC_SAT : bc + 16'd8;
    end_len  = bc + {13'd0, term_lane};
    end_err  = err_seen || word_err || (state == ST_DROP) ||
               (end_len < MIN_LEN) || (end_len > MAX_LEN);
    // Only frames that made it through w5 carry a complete UDP header.
    udp_ok   = (state == ST_PAY) && eth_ok && ver_ok && proto_ok;
  end

  always_ff @(posedge clk156) begin
    if (sys_rst) begin
      state         <= ST_IDLE;
      wi            <= 3'd0;
      bc            <= 16'd0;
      err_seen      <= 1'b0;
      eth_ok        <= 1'b0;
      ver_ok        <= 1'b0;
      proto_ok      <= 1'b0;
      dport         <= 16'd0;
      src_ip        <= 32'd0;
      frame_ok      <= 1'b0;
      udp_hit       <= 1'b0;
      frame_err     <= 1'b0;
      last_len      <= 16'd0;
      last_dst_port <= 16'd0;
      last_src_ip   <= 32'd0;
      frame_cnt     <= '0;
      udp_cnt       <= '0;
      err_cnt       <= '0;
    end else begin
      frame_ok  <= 1'b0;
      udp_hit   <= 1'b0;
      frame_err <= 1'b0;
      if (is_start) begin
        // A start inside a frame aborts the old one and opens a new one here.
        if (in_frame) begin
          frame_err <= 1'b1;
          err_cnt   <= err_cnt + CNT_ONE;
        end
        state    <= ST_HDR;
        wi       <= 3'd1;
        bc       <= 16'd0;
        err_seen <= 1'b0;
        eth_ok   <= 1'b0;
        ver_ok   <= 1'b0;
        proto_ok <= 1'b0;
      end else if (in_frame && term_valid) begin
        state    <= ST_IDLE;
        last_len <= end_len;
        if (end_err) begin
          frame_err <= 1'b1;
          err_cnt   <= err_cnt + CNT_ONE;
        end else begin
          frame_ok  <= 1'b1;
          frame_cnt <= frame_cnt + CNT_ONE;
          if (udp_ok) begin
            last_dst_port <= dport;
            last_src_ip   <= src_ip;
            if (dport == MATCH_UDP_PORT) begin
              udp_hit <= 1'b1;
              udp_cnt <= udp_cnt + CNT_ONE;
            end
          end
        end
      end else if (in_frame) begin
        err_seen <= err_seen || word_err;
        case (state)
          ST_HDR: begin
            bc <= bc_next;
            wi <= wi + 3'd1;
            case (wi)
              3'd2: begin
                eth_ok <= {lane_byte(xgmii_rxd, 4), lane_byte(xgmii_rxd, 5)} == ETHERTYPE_IPV4;
                ver_ok <= lane_byte(xgmii_rxd, 6) == IPV4_VER_IHL;
              end
              3'd3: proto_ok <= lane_byte(xgmii_rxd, 7) == IP_PROTO_UDP;
              3'd4: src_ip <= {lane_byte(xgmii_rxd, 2), lane_byte(xgmii_rxd, 3),
                               lane_byte(xgmii_rxd, 4), lane_byte(xgmii_rxd, 5)};
              3'd5: begin
                dport <= {lane_byte(xgmii_rxd, 4), lane_byte(xgmii_rxd, 5)};
                state <= ST_PAY;
              end
              default: ;
            endcase
          end
          ST_PAY: begin
            bc <= bc_next;
            if (bc_next > MAX_LEN) state <= ST_DROP;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/xgmii_rx_checker.md
Name: xgmii_rx_checker

Overview:
Receive-side frame checker for a 64-bit XGMII lane (for example, xgmii0_rxd/rxc after xgmiisync). It delineates frames using start and terminate control characters and measures frame length. It parses the Ethernet/IPv4/UDP header, flags malformed frames, and maintains statistics counters for LED and debug use. It consumes the frame format produced by the clk156 UDP test generator, making it the loopback checker for that generator.

Parameters:
MATCH_UDP_PORT, 16'd9, UDP destination port counted as a hit
MIN_FRAME_BYTES, 64, runt threshold (DA through FCS inclusive)
MAX_FRAME_BYTES, 1518, oversize threshold
CNT_W, 32, width of statistics counters

Ports:
clk156  in  1  XGMII rx clock, 156.25 MHz
sys_rst  in  1  synchronous, active-high reset
xgmii_rxd  in  64  rx data, lane0 = [7:0], first byte on wire
xgmii_rxc  in  8  rx control, bit n qualifies lane n
frame_ok  out  1  one-cycle pulse: good frame ended
udp_hit  out  1  one-cycle pulse: good IPv4/UDP frame with dport == MATCH_UDP_PORT
frame_err  out  1  one-cycle pulse: frame ended or aborted with an error
last_len  out  16  byte length of the last completed frame
last_dst_port  out  16  UDP dport of the last parsed UDP frame
last_src_ip  out  32  IPv4 source address of the last parsed UDP frame
frame_cnt  out  CNT_W  good frames
udp_cnt  out  CNT_W  udp_hit count
err_cnt  out  CNT_W  error frames

Behaviour:
- Reset: all outputs and counters 0; FSM to IDLE. Reset mid-frame discards the frame with no pulses or counts.
- Start condition: xgmii_rxc[0]==1 and xgmii_rxd[7:0]==8'hFB. Lanes 1-7 of the start word are preamble/SFD and are ignored. Start is recognised on lane 0 only.
- Terminate lane k = lowest lane with rxc[k]==1 and byte==8'hFD. A terminate word contributes k data bytes.
- Error char: any lane with rxc==1 and byte==8'hFE, or any rxc-qualified byte other than FD/07 before the terminate lane, while in frame.
- FSM states:
  - IDLE: on start go to HDR with word index wi=1 and byte count bc=0.
  - HDR: covers wi 1..5. Each data word adds 8 to bc and increments wi. Fields are captured big-endian in wire order, byte b of word w:
    - Ethertype = w2 bytes 4,5; must be 16'h0800.
    - IP version/IHL = w2 byte6; must be 8'h45.
    - Protocol = w3 byte7; must be 8'h11.
    - Source IP = w4 bytes 2..5.
    - Destination port = w5 bytes 4,5.
    - After w5, go to PAYLOAD.
  - PAYLOAD: each data word adds 8 to bc.
  - DROP: entered when bc exceeds MAX_FRAME_BYTES. Wait for terminate without counting. Terminate then yields frame_err.
- Frame end (terminate seen in HDR, PAYLOAD or DROP):
  - len = bc + k, registered into last_len.
  - Pulses are asserted the cycle after the terminate word is sampled (1-cycle latency).
  - frame_err is asserted if an error char was seen, len < MIN, or len > MAX. Otherwise frame_ok.
  - udp_hit is asserted together with frame_ok when all three header checks passed and dport == MATCH_UDP_PORT. last_dst_port and last_src_ip update only on frame_ok with the UDP checks passed.
  - FSM returns to IDLE.
- Start while in frame: current frame is counted as an error (frame_err pulse), and a new frame begins from that word.
- Terminate in HDR before w5 completes: frame is not UDP-eligible. It is a runt by length, so frame_err.
- Terminate in the same word as start is impossible (lane 0 is used by start) and is ignored.
- bc saturates at MAX_FRAME_BYTES+8 and never wraps.
- Counters wrap modulo 2^CNT_W. Each counter increments in the same cycle as its pulse.
- Idle words (all rxc=1, bytes 07) in IDLE have no effect.

Decomposition:
- Shared include (alongside setup.v): XGMII_START 8'hFB, XGMII_TERM 8'hFD, XGMII_ERR 8'hFE, XGMII_IDLE 8'h07, ETHERTYPE_IPV4 16'h0800, IPV4_VER_IHL 8'h45, IP_PROTO_UDP 8'h11.
- Sub-module xgmii_term_detect (combinational): rxd/rxc in; term_valid, term_lane[2:0] (priority, lowest lane), err_char, bad_ctrl out.

Test Plan:
- Generator frame (start word D5555555555555FB/01, eight data words, then 0707070707_0707FD/FF) -> frame_ok, udp_hit, last_len=64, last_dst_port=0x0009, last_src_ip=0xC0A80165, udp_cnt=1, frame_cnt=1.
- Same frame with w2 byte4 changed from 08 to 86 -> frame_ok only, udp_cnt=0, last_dst_port unchanged.
- Frame terminated at lane0 of word 5 -> len 32, frame_err, err_cnt=1.
- 8'hFE with rxc set in lane 3 of word 6 -> frame_err, no frame_ok.
- 200 data words before terminate -> DROP, single frame_err at terminate, frame_cnt unchanged.
- New start at word 4 of a frame, then full generator frame -> frame_err, then frame_ok+udp_hit. sys_rst asserted mid-frame -> all counters 0, no pulses.
